// File: rtl/adder_share_arbiter.sv
// Round-robin share of one 16-bit ripple adder among NUM_REQ accumulators; ADDER_SAT_EN selects saturating results.
// Latency: req in IDLE at t -> gnt t+1 -> done t+2; requests seen while busy are held off, not queued.

module Adder16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_w
);

  logic w_carry;

  always_comb begin
    w_carry = 1'b0;
    o_w     = '0;
    for (int i = 0; i < 16; i++) begin
      o_w[i]  = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
    end
  end

endmodule

module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  a_in,
  input  logic [16*NUM_REQ-1:0]  b_in,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [15:0]            sum_out,
  output logic                   ovf,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_win;
  logic [PTR_W-1:0] w_win;
  logic             w_found;
  int               w_idx;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [15:0]      w_a_sel;
  logic [15:0]      w_b_sel;
  logic [15:0]      w_sum;
  logic [15:0]      w_res;
  logic             w_ovf;

  // Search starts at r_ptr so the previous winner is considered last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = PTR_W'(w_idx);
      end
    end
  end

  assign w_a_sel = a_in[16*int'(w_win) +: 16];
  assign w_b_sel = b_in[16*int'(w_win) +: 16];

  Adder16bit u_adder (
    .i_a (r_a),
    .i_b (r_b),
    .o_w (w_sum)
  );

  assign w_ovf = (r_a[15] == r_b[15]) && (w_sum[15] != r_a[15]);

`ifdef ADDER_SAT_EN
  assign w_res = w_ovf ? (r_a[15] ? 16'h8000 : 16'h7FFF) : w_sum;
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next = ADD;
      ADD:     w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_win   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      sum_out <= '0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_win <= w_win;
            r_a   <= w_a_sel;
            r_b   <= w_b_sel;
          end
        end
        ADD: begin
          sum_out <= w_res;
          ovf     <= w_ovf;
        end
        RESP: begin
          r_ptr <= (r_win == PTR_W'(NUM_REQ-1)) ? '0 : r_win + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt = '0;
    done = '0;
    if (r_state == ADD)  gnt[r_win]  = 1'b1;
    if (r_state == RESP) done[r_win] = 1'b1;
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: expected results queued at stimulus, compared on done.
// Honors ADDER_SAT_EN when computing expected sums.

module tb_adder_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [15:0] sum_out;
  logic        ovf;
  logic        busy;

  typedef struct {
    logic [3:0]  id_oh;
    logic [15:0] sum;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_done = -1;
  bit   gap_en = 0;

  adder_share_arbiter #(.NUM_REQ(4), .PTR_W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .done    (done),
    .sum_out (sum_out),
    .ovf     (ovf),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic        o;
    s = a + b;
    o = (a[15] == b[15]) && (s[15] != a[15]);
`ifdef ADDER_SAT_EN
    if (o) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {o, s};
  endfunction

  task automatic push_exp(input int id, input logic [15:0] a, input logic [15:0] b);
    exp_t        x;
    logic [16:0] m;
    m = model(a, b);
    x.id_oh = 4'b0001 << id;
    x.sum   = m[15:0];
    x.ovf   = m[16];
    sb.push_back(x);
  endtask

  task automatic set_ops(input int id, input logic [15:0] a, input logic [15:0] b);
    a_in[16*id +: 16] = a;
    b_in[16*id +: 16] = b;
  endtask

  task automatic wait_gnt(input int id, input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt[id]) break;
    end
    chk(tag, gnt[id], 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_wait", busy, 1'b0);
  endtask

  task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] m;
    m = model(a, b);
    set_ops(id, a, b);
    push_exp(id, a, b);
    req[id] = 1'b1;
    wait_gnt(id, "op_gnt");
    req[id] = 1'b0;
    wait_idle();
    chk("sum_hold", sum_out, m[15:0]);
    chk("ovf_hold", ovf, m[16]);
  endtask

  task automatic rst_seq();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 4'b0);
    chk("rst_done", done, 4'b0);
    chk("rst_sum", sum_out, 16'h0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done != 4'b0) begin
      if (gap_en && last_done >= 0) chk("done_gap", cyc - last_done, 3);
      last_done = cyc;
      if (sb.size() == 0) begin
        chk("unexp_done", done, 4'b0);
      end else begin
        e = sb.pop_front();
        chk("done_id", done, e.id_oh);
        chk("sum", sum_out, e.sum);
        chk("ovf", ovf, e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    rst_seq();

    // single add with cycle-exact latency
    set_ops(1, 16'h0003, 16'h0004);
    push_exp(1, 16'h0003, 16'h0004);
    req = 4'b0010;
    @(negedge clk);
    chk("t1_gnt", gnt, 4'b0010);
    chk("t1_busy1", busy, 1'b1);
    req = 4'b0000;
    @(negedge clk);
    chk("t1_done", done, 4'b0010);
    chk("t1_gnt_off", gnt, 4'b0000);
    chk("t1_busy2", busy, 1'b1);
    @(negedge clk);
    chk("t1_idle", busy, 1'b0);
    chk("t1_done_off", done, 4'b0000);

    // all requesters held high: order 0,1,2,3 twice, done every 3 cycles
    rst_seq();
    for (int i = 0; i < 4; i++) set_ops(i, 16'(16'h0100 * i + 1), 16'(16'h0010 + i));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) push_exp(i, 16'(16'h0100 * i + 1), 16'(16'h0010 + i));
    gap_en = 1;
    last_done = -1;
    n = 0;
    req = 4'b1111;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done != 4'b0) n++;
      if (n == 8) break;
    end
    req = 4'b0000;
    chk("t2_count", n, 8);
    wait_idle();
    gap_en = 0;

    // overflow, negative and wrap cases
    do_op(0, 16'h7FFF, 16'h0001);
    do_op(3, 16'h8000, 16'hFFFF);
    do_op(2, 16'hFFFE, 16'hFFFF);
    do_op(1, 16'hFFFF, 16'h0001);

    // reset during ADD of requester 2 aborts it and clears the pointer
    set_ops(2, 16'h1111, 16'h2222);
    req = 4'b0100;
    wait_gnt(2, "t5_gnt2");
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    chk("t5_sum", sum_out, 16'h0);
    chk("t5_done", done, 4'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_gnt", gnt, 4'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_nodone", done, 4'b0);
    rst_n = 1'b1;
    set_ops(0, 16'h0123, 16'h0456);
    push_exp(0, 16'h0123, 16'h0456);
    req = 4'b1111;
    @(negedge clk);
    chk("t5_gnt0", gnt, 4'b0001);
    req = 4'b0000;
    wait_idle();

    // late arrival of requester 3 during ADD of requester 0
    set_ops(0, 16'h0A00, 16'h00B0);
    push_exp(0, 16'h0A00, 16'h00B0);
    req = 4'b0001;
    wait_gnt(0, "t6_gnt0");
    set_ops(3, 16'h4000, 16'h4000);
    push_exp(3, 16'h4000, 16'h4000);
    req = 4'b1000;
    @(negedge clk);
    chk("t6_resp_gnt", gnt, 4'b0000);
    @(negedge clk);
    chk("t6_idle_gnt", gnt, 4'b0000);
    chk("t6_idle_busy", busy, 1'b0);
    @(negedge clk);
    chk("t6_gnt3", gnt, 4'b1000);
    req = 4'b0000;
    wait_idle();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
